// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor: FSM state encoding.
package serial_addsub_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// One-bit full adder used as the single arithmetic cell of serial_addsub.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, one full-adder cell with a registered carry.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output ovf.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   sum_sr;
  logic [WIDTH-1:0]   sum_shift;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;
  logic               fa_s;
  logic               fa_c;

  fa_cell u_fa (
    .a   (op_a[0]),
    .b   (op_b[0]),
    .cin (carry),
    .s   (fa_s),
    .c   (fa_c)
  );

  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
  // New result bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign sum_shift = (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 comes in as the initial carry.
            op_a   <= a;
            op_b   <= sub ? ~b : b;
            carry  <= sub;
            cnt    <= '0;
            sum_sr <= '0;
          end
        end
        RUN: begin
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          sum_sr <= sum_shift;
          carry  <= fa_c;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= sum_shift;
            cout <= fa_c;
`ifdef SERIAL_ADDSUB_OVF_EN
            // On the last bit, carry holds the carry into the MSB.
            ovf  <= carry ^ fa_c;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): timing/result model plus directed literals.
// Checks ovf only when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int fails  = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: unsigned modulo result/carry and signed range overflow.
  function automatic void model_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                   output logic [W-1:0] r, output logic c, output logic o);
    logic [W:0] full;
    longint     sv;
    if (s) full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   full = {1'b0, x} + {1'b0, y};
    r  = full[W-1:0];
    c  = full[W];
    sv = s ? (longint'($signed(x)) - longint'($signed(y)))
           : (longint'($signed(x)) + longint'($signed(y)));
    o  = (sv > ((longint'(1) <<< (W-1)) - 1)) || (sv < -(longint'(1) <<< (W-1)));
  endfunction

  // Model: rem counts cycles left until back in idle (W+1 after capture; 1 = done cycle).
  int           rem = 0;
  logic [W-1:0] pend_sum = '0, exp_sum = '0;
  logic         pend_cout = 1'b0, exp_cout = 1'b0;
  logic         pend_ovf = 1'b0, exp_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem = 0;
      exp_sum = '0;
      exp_cout = 1'b0;
      exp_ovf = 1'b0;
    end else if (rem > 0) begin
      rem = rem - 1;
      if (rem == 1) begin
        exp_sum  = pend_sum;
        exp_cout = pend_cout;
        exp_ovf  = pend_ovf;
      end
    end else if (start) begin
      model_op(a, b, sub, pend_sum, pend_cout, pend_ovf);
      rem = W + 1;
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(rem > 1));
    chk("done", 64'(done), 64'(rem == 1));
    chk("sum", 64'(sum), 64'(exp_sum));
    chk("cout", 64'(cout), 64'(exp_cout));
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("ovf", 64'(ovf), 64'(exp_ovf));
`endif
    if (busy && done) chk("busy_and_done", 64'(1), 64'(0));
  end

  task automatic pulse_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    @(posedge clk); #1;
    start = 1'b1; a = x; b = y; sub = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Directed op: checks done latency and literal results; optionally injects a start in cycle 3.
  task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input logic [W-1:0] r, input logic c, input logic o,
                          input bit poke);
    int lat = 0;
    int ndone = 0;
    pulse_start(x, y, s);
    for (int i = 1; i <= W + 5; i++) begin
      if (poke && i == 3) begin
        start = 1'b1; a = ~x; b = ~y; sub = ~s;
      end
      @(negedge clk);
      if (poke && i == 3) begin
        @(posedge clk); #1;
        start = 1'b0;
        i++;
        @(negedge clk);
      end
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = i;
          chk({name, "_sum"}, 64'(sum), 64'(r));
          chk({name, "_cout"}, 64'(cout), 64'(c));
`ifdef SERIAL_ADDSUB_OVF_EN
          chk({name, "_ovf"}, 64'(ovf), 64'(o));
`endif
        end
      end
    end
    chk({name, "_latency"}, 64'(lat), 64'(W + 1));
    chk({name, "_done_count"}, 64'(ndone), 64'(1));
    chk({name, "_sum_held"}, 64'(sum), 64'(r));
    $display("op %s: a=0x%02h b=0x%02h sub=%0d -> sum=0x%02h cout=%0d latency=%0d",
             name, x, y, s, sum, cout, lat);
    if (o) ; // ovf expectation used only when the port exists
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_sum", 64'(sum), 64'(0));
    chk("reset_cout", 64'(cout), 64'(0));
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("reset_ovf", 64'(ovf), 64'(0));
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    $display("reset released");

    directed("add",     8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
    directed("wrap",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    directed("ovf_add", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    directed("sub_pos", 8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
    directed("sub_neg", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    directed("sub_zero", 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    directed("busy_start", 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1);

    // Reset mid-operation: abort in cycle 4, outputs clear at once, no done afterwards.
    pulse_start(8'hC3, 8'h5A, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_sum", 64'(sum), 64'(0));
    chk("midrst_cout", 64'(cout), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", 64'(ndone), 64'(0));
    $display("op midrst: aborted in cycle 4, done pulses after release=%0d", ndone);
    directed("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    // Randomized traffic: random gaps, and start sometimes held with changing operands.
    for (int n = 0; n < 300; n++) begin
      int hold;
      int gap;
      hold = $urandom_range(1, W + 4);
      gap  = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        start = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        sub = 1'($urandom);
      end
      @(posedge clk); #1 start = 1'b0;
      repeat (gap) @(posedge clk);
      $display("rand %0d: hold=%0d gap=%0d last a=0x%02h b=0x%02h sub=%0d sum=0x%02h",
               n, hold, gap, a, b, sub, sum);
    end
    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
